// File: rtl/req_2ph_sync_sink.sv
// Clocked sink for a 2-phase r/a request channel: each r transition becomes one
// valid/ready event, acknowledged by toggling a. Also counts events and flags protocol errors.
module req_2ph_sync_sink #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               r,
  output logic               a,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [COUNT_W-1:0] evt_count,
  input  logic               cnt_clr,
  output logic               proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 r_a;
  logic [COUNT_W-1:0]   r_cnt;
  logic                 r_err;
  logic                 w_r_s;
  logic                 w_pending;
  logic                 w_accept;
  logic                 w_violation;

  assign w_r_s     = r_sync[SYNC_STAGES-1];
  assign w_pending = w_r_s ^ r_a;

  // r is asynchronous to clk; only the last synchronizer stage is used downstream.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], r};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_violation = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pending) w_state_nxt = VALID;
      end
      VALID: begin
        if (evt_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ACK;
        end else if (!w_pending) begin
          // r returned to the acknowledged phase before the handshake
          w_violation = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      ACK: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a   <= 1'b0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) r_a <= ~r_a;
      // Clear wins over a same-cycle increment; the event is still acknowledged.
      if (cnt_clr) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + COUNT_W'(1);
      end
      if (w_violation) r_err <= 1'b1;
    end
  end

  assign a         = r_a;
  assign evt_valid = (r_state == VALID);
  assign evt_count = r_cnt;
  assign proto_err = r_err;

endmodule
